// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate BIST sequencer.
// - bist_state_t : sequencer state encoding (also exported on the debug state port)
// - NUM_VEC, VEC_W, ERR_W : vector count and field widths
// - TT_* : truth tables for common gates, bit i = output for input vector i = {a,b}
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } bist_state_t;

  localparam int NUM_VEC = 4;
  localparam int VEC_W   = 2;
  localparam int ERR_W   = 3;

  localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/settle_timer.sv
// 8-bit loadable down-counter that times how long a vector is held.
// Ports:
// - clk, reset : clock and synchronous active-high reset
// - load       : load load_val (has priority over en)
// - load_val   : value to load
// - en         : decrement by one per cycle, saturating at zero
// - expired    : count is zero
module settle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign expired = (count == 8'd0);

endmodule

// File: rtl/gate_bist.sv
// Built-in self-test sequencer for one 2-input combinational gate.
// On an accepted start it applies vectors 00,01,10,11 (a = MSB), holds each
// for SETTLE cycles plus one CHECK cycle, samples the gate output at the end
// of CHECK and compares it with the truth table latched at start.
// Ports:
// - clk, reset   : clock and synchronous active-high reset
// - start        : begin a run (honoured only in IDLE)
// - expected     : truth table, bit i = required output for vector i
// - dut_a, dut_b : registered gate inputs
// - dut_out      : gate output
// - busy         : run in progress (low again in DONE)
// - done         : one-cycle pulse, results valid
// - pass         : all vectors matched (held until next start)
// - fail_mask    : per-vector mismatch flags (held)
// - err_count    : number of mismatches (held)
// - state        : current sequencer state, for debug
//
// Handshake: start is a level sampled at the rising edge while in IDLE;
// there is no ready signal, a start outside IDLE is dropped, and done is a
// single-cycle strobe with results remaining valid afterwards.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NUM_VEC-1:0] expected,
  output logic               dut_a,
  output logic               dut_b,
  input  logic               dut_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] fail_mask,
  output logic [ERR_W-1:0]   err_count,
  output bist_state_t        state
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

  logic [VEC_W-1:0]   idx;
  logic [NUM_VEC-1:0] exp_q;
  logic               mismatch;
  logic [NUM_VEC-1:0] fail_next;
  logic               timer_load;
  logic               timer_en;
  logic               timer_expired;

  // fail_next includes the current CHECK result so pass can be computed on
  // the same edge that records the final mismatch.
  always_comb begin
    mismatch   = (dut_out != exp_q[idx]);
    fail_next  = fail_mask;
    if (mismatch) begin
      fail_next = fail_mask | NUM_VEC'(4'b0001 << idx);
    end
    timer_load = ((state == ST_IDLE) && start) ||
                 ((state == ST_CHECK) && (idx != 2'd3));
    timer_en   = (state == ST_SETTLE);
  end

  settle_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .en       (timer_en),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      exp_q     <= '0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      err_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done  <= 1'b0;
          dut_a <= 1'b0;
          dut_b <= 1'b0;
          if (start) begin
            exp_q     <= expected;
            fail_mask <= '0;
            err_count <= '0;
            pass      <= 1'b0;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (timer_expired) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          fail_mask <= fail_next;
          if (mismatch) begin
            err_count <= err_count + 3'd1;
          end
          if (idx == 2'd3) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_next == '0);
            dut_a <= 1'b0;
            dut_b <= 1'b0;
            state <= ST_DONE;
          end else begin
            idx            <= idx + 2'd1;
            {dut_a, dut_b} <= idx + 2'd1;
            state          <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist.sv
module tb_gate_bist;
  import gate_bist_pkg::*;

  localparam logic [2:0] G_AND = 3'd0, G_OR = 3'd1, G_NAND = 3'd2,
                         G_XOR = 3'd3, G_STUCK0 = 3'd4, G_STUCK1 = 3'd5;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // stimulus for two instances: SETTLE=1 (suffix 1) and SETTLE=3 (suffix 3)
  logic       start1 = 1'b0, start3 = 1'b0;
  logic [3:0] expected1 = '0, expected3 = '0;
  logic [2:0] gate1 = G_AND, gate3 = G_AND;

  logic a1, b1, out1, busy1, done1, pass1;
  logic a3, b3, out3, busy3, done3, pass3;
  logic [3:0] mask1, mask3;
  logic [2:0] err1, err3;
  bist_state_t st1, st3;

  function automatic logic gate_fn(input logic [2:0] g, input logic a, input logic b);
    case (g)
      G_AND:    return a & b;
      G_OR:     return a | b;
      G_NAND:   return ~(a & b);
      G_XOR:    return a ^ b;
      G_STUCK0: return 1'b0;
      default:  return 1'b1;
    endcase
  endfunction

  assign out1 = gate_fn(gate1, a1, b1);
  assign out3 = gate_fn(gate3, a3, b3);

  gate_bist #(.SETTLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .expected(expected1),
    .dut_a(a1), .dut_b(b1), .dut_out(out1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_mask(mask1), .err_count(err1), .state(st1)
  );

  gate_bist #(.SETTLE(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .expected(expected3),
    .dut_a(a3), .dut_b(b3), .dut_out(out3), .busy(busy3), .done(done3),
    .pass(pass3), .fail_mask(mask3), .err_count(err3), .state(st3)
  );

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // sampled outputs of the selected instance
  logic       c_a, c_b, c_busy, c_done, c_pass;
  logic [3:0] c_mask;
  logic [2:0] c_err;
  logic [1:0] c_state;

  task automatic sample(input int sel);
    if (sel == 1) begin
      c_a = a1; c_b = b1; c_busy = busy1; c_done = done1; c_pass = pass1;
      c_mask = mask1; c_err = err1; c_state = st1;
    end else begin
      c_a = a3; c_b = b3; c_busy = busy3; c_done = done3; c_pass = pass3;
      c_mask = mask3; c_err = err3; c_state = st3;
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start1 = v; else start3 = v;
  endtask

  task automatic set_exp(input int sel, input logic [3:0] e);
    if (sel == 1) expected1 = e; else expected3 = e;
  endtask

  task automatic set_gate(input int sel, input logic [2:0] g);
    if (sel == 1) gate1 = g; else gate3 = g;
  endtask

  // One complete run on instance sel (SETTLE=s). Checks the vector sequence,
  // busy and done every cycle, the results at done, and that they hold after.
  task automatic run_check(input int sel, input int s, input logic [3:0] tt,
                           input logic mid_change, input logic [3:0] mid_tt,
                           input logic exp_pass, input logic [3:0] exp_mask,
                           input logic [2:0] exp_err, input string name);
    int last;
    logic [1:0] vec;
    last = 4 * (s + 1);
    @(negedge clk);
    set_start(sel, 1'b1);
    set_exp(sel, tt);
    @(posedge clk);  // edge 0
    @(negedge clk);
    set_start(sel, 1'b0);
    for (int n = 0; n <= last; n++) begin
      sample(sel);
      if (mid_change && n == 2) set_exp(sel, mid_tt);
      if (n < last) begin
        vec = 2'(n / (s + 1));
        chk({name, "_vec"}, {6'd0, c_a, c_b}, {6'd0, vec});
        chk({name, "_busy"}, c_busy, 1'b1);
        chk({name, "_nodone"}, c_done, 1'b0);
        @(posedge clk);
        @(negedge clk);
      end else begin
        chk({name, "_done"}, c_done, 1'b1);
        chk({name, "_busy_done"}, c_busy, 1'b0);
        chk({name, "_vec_done"}, {6'd0, c_a, c_b}, 8'd0);
        chk({name, "_pass"}, c_pass, exp_pass);
        chk({name, "_mask"}, c_mask, exp_mask);
        chk({name, "_err"}, c_err, exp_err);
      end
    end
    @(posedge clk);
    @(negedge clk);
    sample(sel);
    chk({name, "_idle"}, c_state, ST_IDLE);
    chk({name, "_done_low"}, c_done, 1'b0);
    chk({name, "_pass_hold"}, c_pass, exp_pass);
    chk({name, "_mask_hold"}, c_mask, exp_mask);
    chk({name, "_err_hold"}, c_err, exp_err);
  endtask

  typedef struct {
    logic [2:0] gate;
    int         s;
    logic [3:0] tt;
    logic       pass;
    logic [3:0] mask;
    logic [2:0] err;
    string      name;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic saw_done;
    int sel;

    // hand-computed table: gate output vs truth table
    tbl[0] = '{G_AND,    1, TT_AND,  1'b1, 4'b0000, 3'd0, "and_and"};
    tbl[1] = '{G_AND,    1, TT_OR,   1'b0, 4'b0110, 3'd2, "and_or"};
    tbl[2] = '{G_STUCK1, 1, TT_AND,  1'b0, 4'b0111, 3'd3, "stuck1_and"};
    tbl[3] = '{G_XOR,    1, TT_XOR,  1'b1, 4'b0000, 3'd0, "xor_xor"};
    tbl[4] = '{G_XOR,    1, TT_NAND, 1'b0, 4'b0001, 3'd1, "xor_nand"};
    tbl[5] = '{G_NAND,   1, TT_AND,  1'b0, 4'b1111, 3'd4, "nand_and"};
    tbl[6] = '{G_STUCK0, 1, TT_NAND, 1'b0, 4'b0111, 3'd3, "stuck0_nand"};
    tbl[7] = '{G_OR,     3, TT_OR,   1'b1, 4'b0000, 3'd0, "or_or_s3"};

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 3; k += 2) begin
      sample(k);
      chk("rst_state", c_state, ST_IDLE);
      chk("rst_outs", {c_a, c_b, c_busy, c_done, c_pass, c_err},
          8'd0);
      chk("rst_mask", c_mask, 4'd0);
    end

    // table-driven runs
    for (int i = 0; i < 8; i++) begin
      sel = (tbl[i].s == 1) ? 1 : 3;
      set_gate(sel, tbl[i].gate);
      run_check(sel, tbl[i].s, tbl[i].tt, 1'b0, 4'd0,
                tbl[i].pass, tbl[i].mask, tbl[i].err, tbl[i].name);
    end

    // expected changes mid-run: latched table still used
    set_gate(1, G_AND);
    run_check(1, 1, TT_AND, 1'b1, TT_OR, 1'b1, 4'b0000, 3'd0, "mid_exp");

    // reset one cycle after edge 5 of a run (previous run left pass=1)
    @(negedge clk);
    start1 = 1'b1;
    expected1 = TT_OR;
    @(posedge clk);  // edge 0
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) @(posedge clk);  // edge 5
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sample(1);
    chk("midrst_state", c_state, ST_IDLE);
    chk("midrst_outs", {c_a, c_b, c_busy, c_done, c_pass, c_err}, 8'd0);
    chk("midrst_mask", c_mask, 4'd0);
    saw_done = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done1 === 1'b1 || st1 !== ST_IDLE) saw_done = 1'b1;
    end
    chk("midrst_quiet", saw_done, 1'b0);

    // start held high: one run per IDLE entry, restart right after DONE
    @(negedge clk);
    gate1 = G_AND;
    expected1 = TT_AND;
    start1 = 1'b1;
    @(posedge clk);  // edge 0
    for (int n = 1; n <= 19; n++) begin
      @(posedge clk);
      @(negedge clk);
      sample(1);
      chk($sformatf("held_done_%0d", n), c_done, (n == 8 || n == 18));
      chk($sformatf("held_busy_%0d", n), c_busy,
          !(n == 8 || n == 9 || n == 18 || n == 19));
      if (n == 9) chk("held_idle_9", c_state, ST_IDLE);
      if (n == 10) chk("held_settle_10", c_state, ST_SETTLE);
      if (n == 18) chk("held_pass_18", c_pass, 1'b1);
    end
    start1 = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
